// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the in-order pipeline and buffered
// multiplier/divider results; round-robin between units, forced drain on starvation.
module wb_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic        hold,
    input  logic        pipe_regwrite,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_res,
    input  logic        mul_valid,
    input  logic [4:0]  mul_rd,
    input  logic [31:0] mul_res,
    output logic        mul_ready,
    input  logic        div_valid,
    input  logic [4:0]  div_rd,
    input  logic [31:0] div_res,
    output logic        div_ready,
    output logic        wb_regwrite,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_res,
    output logic [1:0]  wb_src,
    output logic        stall_req,
    output logic [31:0] pending_mask
);
    localparam logic [7:0] LIMIT_M1 = 8'(STARVE_LIMIT - 1);

    // Unit index 0 is the multiplier, 1 the divider.
    logic [1:0]  in_valid;
    logic [4:0]  in_rd   [2];
    logic [31:0] in_res  [2];
    logic [1:0]  in_ready;

    logic [1:0]  hv_q, hv_d;
    logic [4:0]  hrd_q   [2];
    logic [4:0]  hrd_d   [2];
    logic [31:0] hres_q  [2];
    logic [31:0] hres_d  [2];
    logic        last_div_q, last_div_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        starve_q, starve_d;
    logic        wb_we_q, wb_we_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_res_q, wb_res_d;
    logic [1:0]  wb_src_q, wb_src_d;

    logic        slot_free;
    logic [1:0]  gnt;

    assign in_valid  = {div_valid, mul_valid};
    assign in_rd[0]  = mul_rd;
    assign in_rd[1]  = div_rd;
    assign in_res[0] = mul_res;
    assign in_res[1] = div_res;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_unit
            assign in_ready[gi] = !Rst && !hold && !hv_q[gi];
        end
        for (gi = 0; gi < 32; gi++) begin : g_pend
            assign pending_mask[gi] = (hv_q[0] && (hrd_q[0] == 5'(gi)))
                                   || (hv_q[1] && (hrd_q[1] == 5'(gi)));
        end
    endgenerate

    assign mul_ready = in_ready[0];
    assign div_ready = in_ready[1];

    // A forced-drain cycle frees the slot; upstream re-presents the pipe result.
    always_comb begin
        slot_free = !pipe_regwrite || (pipe_rd == 5'd0) || starve_q;
        gnt       = 2'b00;
        if (slot_free) begin
            if (hv_q == 2'b11) begin
                gnt = last_div_q ? 2'b01 : 2'b10;
            end else begin
                gnt = hv_q;
            end
        end
    end

    always_comb begin
        hv_d       = hv_q;
        hrd_d      = hrd_q;
        hres_d     = hres_q;
        last_div_d = last_div_q;
        cnt_d      = cnt_q;
        starve_d   = starve_q;
        wb_we_d    = wb_we_q;
        wb_rd_d    = wb_rd_q;
        wb_res_d   = wb_res_q;
        wb_src_d   = wb_src_q;
        if (!hold) begin
            // rd==0 results complete the handshake but are never stored.
            for (int i = 0; i < 2; i++) begin
                if (gnt[i]) begin
                    hv_d[i] = 1'b0;
                end else if (in_valid[i] && in_ready[i] && (in_rd[i] != 5'd0)) begin
                    hv_d[i]   = 1'b1;
                    hrd_d[i]  = in_rd[i];
                    hres_d[i] = in_res[i];
                end
            end

            if (gnt != 2'b00) begin
                last_div_d = gnt[1];
            end

            if ((gnt != 2'b00) || (hv_q == 2'b00)) begin
                cnt_d    = 8'd0;
                starve_d = 1'b0;
            end else begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == LIMIT_M1) begin
                    starve_d = 1'b1;
                end
            end

            if (gnt[0]) begin
                wb_we_d  = 1'b1;
                wb_rd_d  = hrd_q[0];
                wb_res_d = hres_q[0];
                wb_src_d = 2'b01;
            end else if (gnt[1]) begin
                wb_we_d  = 1'b1;
                wb_rd_d  = hrd_q[1];
                wb_res_d = hres_q[1];
                wb_src_d = 2'b10;
            end else begin
                wb_we_d  = !slot_free;
                wb_rd_d  = pipe_rd;
                wb_res_d = pipe_res;
                wb_src_d = 2'b00;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            hv_q       <= 2'b00;
            hrd_q      <= '{default: '0};
            hres_q     <= '{default: '0};
            last_div_q <= 1'b1;
            cnt_q      <= 8'd0;
            starve_q   <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_res_q   <= 32'd0;
            wb_src_q   <= 2'b00;
        end else begin
            hv_q       <= hv_d;
            hrd_q      <= hrd_d;
            hres_q     <= hres_d;
            last_div_q <= last_div_d;
            cnt_q      <= cnt_d;
            starve_q   <= starve_d;
            wb_we_q    <= wb_we_d;
            wb_rd_q    <= wb_rd_d;
            wb_res_q   <= wb_res_d;
            wb_src_q   <= wb_src_d;
        end
    end

    assign wb_regwrite = wb_we_q;
    assign wb_rd       = wb_rd_q;
    assign wb_res      = wb_res_q;
    assign wb_src      = wb_src_q;
    assign stall_req   = starve_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: behavioural model compared every cycle plus
// hand-computed checkpoints for each scenario.
module tb_wb_port_arbiter;
    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        Rst, hold;
    logic        pipe_regwrite;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_res;
    logic        mul_valid, div_valid;
    logic [4:0]  mul_rd, div_rd;
    logic [31:0] mul_res, div_res;
    logic        mul_ready, div_ready;
    logic        wb_regwrite;
    logic [4:0]  wb_rd;
    logic [31:0] wb_res;
    logic [1:0]  wb_src;
    logic        stall_req;
    logic [31:0] pending_mask;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    wb_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .Rst(Rst), .hold(hold),
        .pipe_regwrite(pipe_regwrite), .pipe_rd(pipe_rd), .pipe_res(pipe_res),
        .mul_valid(mul_valid), .mul_rd(mul_rd), .mul_res(mul_res), .mul_ready(mul_ready),
        .div_valid(div_valid), .div_rd(div_rd), .div_res(div_res), .div_ready(div_ready),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_res(wb_res), .wb_src(wb_src),
        .stall_req(stall_req), .pending_mask(pending_mask)
    );

    // Behavioural model: per-unit buffers, index of last granted unit, waiting time.
    bit          m_bv [2];
    logic [4:0]  m_brd [2];
    logic [31:0] m_bres [2];
    int          m_last;
    int          m_wait;
    bit          m_stall;
    bit          m_we;
    logic [4:0]  m_rd;
    logic [31:0] m_res;
    logic [1:0]  m_src;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_mask();
        logic [31:0] m;
        m = 32'd0;
        for (int i = 0; i < 2; i++) if (m_bv[i]) m[m_brd[i]] = 1'b1;
        return m;
    endfunction

    // Applies the arbitration rules to the inputs seen at this clock edge.
    task automatic model_step();
        bit          in_v [2];
        logic [4:0]  in_r [2];
        logic [31:0] in_d [2];
        bit          free, any;
        int          g;
        in_v[0] = mul_valid; in_r[0] = mul_rd; in_d[0] = mul_res;
        in_v[1] = div_valid; in_r[1] = div_rd; in_d[1] = div_res;
        if (Rst) begin
            m_bv[0] = 0; m_bv[1] = 0; m_last = 1; m_wait = 0; m_stall = 0;
            m_we = 0; m_rd = 0; m_res = 0; m_src = 0;
            return;
        end
        if (hold) return;
        free = !pipe_regwrite || (pipe_rd == 0) || m_stall;
        any  = m_bv[0] || m_bv[1];
        g = -1;
        if (free && m_bv[0] && m_bv[1]) g = 1 - m_last;
        else if (free && m_bv[0]) g = 0;
        else if (free && m_bv[1]) g = 1;
        if (g >= 0) begin
            m_we = 1; m_rd = m_brd[g]; m_res = m_bres[g]; m_src = 2'(g + 1); m_last = g;
        end else begin
            m_we = !free; m_rd = pipe_rd; m_res = pipe_res; m_src = 2'b00;
        end
        if (g >= 0 || !any) begin
            m_wait = 0; m_stall = 0;
        end else begin
            if (m_wait == LIMIT - 1) m_stall = 1;
            m_wait++;
        end
        for (int i = 0; i < 2; i++) begin
            if (i == g) m_bv[i] = 0;
            else if (in_v[i] && !m_bv[i] && in_r[i] != 0) begin
                m_bv[i] = 1; m_brd[i] = in_r[i]; m_bres[i] = in_d[i];
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_wb_regwrite", 32'(wb_regwrite), 32'(m_we));
            chk("cyc_wb_rd", 32'(wb_rd), 32'(m_rd));
            chk("cyc_wb_res", wb_res, m_res);
            chk("cyc_wb_src", 32'(wb_src), 32'(m_src));
            chk("cyc_stall_req", 32'(stall_req), 32'(m_stall));
            chk("cyc_pending_mask", pending_mask, exp_mask());
            chk("cyc_mul_ready", 32'(mul_ready), 32'(!Rst && !hold && !m_bv[0]));
            chk("cyc_div_ready", 32'(div_ready), 32'(!Rst && !hold && !m_bv[1]));
            if (wb_regwrite)
                $display("[TB] t=%0t write rd=%0d res=0x%0h src=%0d", $time, wb_rd, wb_res, wb_src);
        end
    end

    initial begin
        Rst = 1; hold = 0;
        pipe_regwrite = 0; pipe_rd = 0; pipe_res = 0;
        mul_valid = 1; mul_rd = 5'd3; mul_res = 32'hAA;
        div_valid = 0; div_rd = 0; div_res = 0;

        // Reset with a multiplier result held valid
        tick(); chk_en = 1; tick();
        chk("rst_mul_ready", 32'(mul_ready), 0);
        chk("rst_wb_regwrite", 32'(wb_regwrite), 0);
        chk("rst_wb_res", wb_res, 0);
        chk("rst_stall", 32'(stall_req), 0);
        chk("rst_mask", pending_mask, 0);
        Rst = 0; tick();
        mul_valid = 0;
        chk("postrst_accept_mask", pending_mask, 32'h8);
        tick();
        chk("postrst_drain_rd", 32'(wb_rd), 3);
        chk("postrst_drain_src", 32'(wb_src), 1);

        // Single multiplier result, pipe idle
        mul_valid = 1; mul_rd = 5'd5; mul_res = 32'h1234; tick();
        mul_valid = 0;
        chk("mul_mask", pending_mask, 32'h20);
        tick();
        chk("mul_we", 32'(wb_regwrite), 1);
        chk("mul_rd", 32'(wb_rd), 5);
        chk("mul_res", wb_res, 32'h1234);
        chk("mul_src", 32'(wb_src), 1);
        chk("mul_mask_clear", pending_mask, 0);

        // Both units at once, last grant was mul -> div first
        mul_valid = 1; mul_rd = 5'd6; mul_res = 32'h66;
        div_valid = 1; div_rd = 5'd7; div_res = 32'h77; tick();
        mul_valid = 0; div_valid = 0;
        chk("both_mask", pending_mask, 32'hC0);
        tick();
        chk("both_a_src", 32'(wb_src), 2);
        chk("both_a_rd", 32'(wb_rd), 7);
        tick();
        chk("both_b_src", 32'(wb_src), 1);
        chk("both_b_res", wb_res, 32'h66);

        // Lone div grant moves the pointer to div, then both -> mul first
        div_valid = 1; div_rd = 5'd9; div_res = 32'h99; tick();
        div_valid = 0; tick();
        chk("lone_div_src", 32'(wb_src), 2);
        mul_valid = 1; mul_rd = 5'd14; mul_res = 32'hE;
        div_valid = 1; div_rd = 5'd15; div_res = 32'hF; tick();
        mul_valid = 0; div_valid = 0; tick();
        chk("both2_a_rd", 32'(wb_rd), 14);
        tick();
        chk("both2_b_rd", 32'(wb_rd), 15);

        // Starvation under continuous pipe writes
        pipe_regwrite = 1; pipe_rd = 5'd1; pipe_res = 100;
        div_valid = 1; div_rd = 5'd10; div_res = 32'hD10; tick();
        div_valid = 0;
        for (int k = 1; k <= 8; k++) begin
            pipe_res = 32'(100 + k); tick();
            if (k == 7) chk("starve_early", 32'(stall_req), 0);
            if (k == 8) chk("starve_stall", 32'(stall_req), 1);
        end
        pipe_res = 109; tick();
        chk("starve_drain_src", 32'(wb_src), 2);
        chk("starve_drain_rd", 32'(wb_rd), 10);
        chk("starve_one_cycle", 32'(stall_req), 0);
        tick();
        chk("starve_pipe_res", wb_res, 109);
        chk("starve_pipe_src", 32'(wb_src), 0);

        // Hold for 3 cycles with a buffered mul result and pipe writes pending
        pipe_rd = 5'd2; pipe_res = 32'h200;
        mul_valid = 1; mul_rd = 5'd12; mul_res = 32'hC; tick();
        mul_valid = 0; hold = 1; pipe_res = 32'h201;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("hold_wb_res", wb_res, 32'h200);
            chk("hold_ready", 32'(mul_ready), 0);
        end
        hold = 0;
        for (int k = 1; k <= 8; k++) begin
            pipe_res = 32'(32'h202 + k); tick();
            if (k == 1) chk("hold_release_res", wb_res, 32'h203);
            if (k == 7) chk("hold_cnt_frozen", 32'(stall_req), 0);
            if (k == 8) chk("hold_stall", 32'(stall_req), 1);
        end
        tick();
        chk("hold_drain_rd", 32'(wb_rd), 12);
        pipe_regwrite = 0; tick();

        // Unit result to x0: handshake completes, nothing written
        div_valid = 1; div_rd = 5'd0; div_res = 32'hBAD;
        chk("rd0_ready", 32'(div_ready), 1);
        tick();
        div_valid = 0;
        chk("rd0_mask", pending_mask, 0);
        chk("rd0_not_stored", 32'(div_ready), 1);
        tick();
        chk("rd0_no_write", 32'(wb_regwrite), 0);

        // Reset overrides hold and drops a buffered result
        pipe_regwrite = 1; pipe_rd = 5'd4; pipe_res = 32'h44;
        mul_valid = 1; mul_rd = 5'd20; mul_res = 32'h20; tick();
        mul_valid = 0; pipe_regwrite = 0;
        chk("prerst_mask", pending_mask, 32'h0010_0000);
        hold = 1; Rst = 1; tick();
        chk("rsthold_mask", pending_mask, 0);
        chk("rsthold_we", 32'(wb_regwrite), 0);
        Rst = 0; hold = 0; tick(); tick();

        @(negedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
